// File: rtl/traffic_mon_pkg.sv
// Shared lamp-state encoding, fault codes and lamp decode for the traffic conflict monitor.
package traffic_mon_pkg;

  typedef enum logic [1:0] {
    ST_RED = 2'd0,
    ST_GRN = 2'd1,
    ST_YLW = 2'd2,
    ST_BAD = 2'd3
  } lamp_st_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_LAMP     = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_YSHORT   = 3'd4;
  localparam logic [2:0] FC_YLONG    = 3'd5;

  // Exactly one lamp lit gives a colour; dark or multiple lamps is BAD.
  function automatic lamp_st_e decode_lamps(input logic grn, input logic ylw, input logic red);
    lamp_st_e st;
    case ({grn, ylw, red})
      3'b001:  st = ST_RED;
      3'b100:  st = ST_GRN;
      3'b010:  st = ST_YLW;
      default: st = ST_BAD;
    endcase
    return st;
  endfunction

  function automatic logic has_right_of_way(input lamp_st_e st);
    return (st == ST_GRN) || (st == ST_YLW);
  endfunction

endpackage

// File: rtl/lamp_dir_checker.sv
// Per-direction lamp decode, tracked colour state, yellow interval counter and
// the LAMP/SEQ/YSHORT/YLONG rule flags for one registered lamp sample.
module lamp_dir_checker
  import traffic_mon_pkg::*;
#(
  parameter int MIN_YLW = 2,
  parameter int MAX_YLW = 8,
  parameter int CNT_W   = 4
) (
  input  logic       ck_i,
  input  logic       clr_i,
  input  logic       grn_i,
  input  logic       ylw_i,
  input  logic       red_i,
  output logic [1:0] dec_o,
  output logic [1:0] st_o,
  output logic       lamp_o,
  output logic       seq_o,
  output logic       yshort_o,
  output logic       ylong_o
);

  localparam logic [CNT_W-1:0] YMIN = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] YMAX = CNT_W'(MAX_YLW);
  localparam logic [CNT_W-1:0] YSAT = CNT_W'(MAX_YLW + 1);

  lamp_st_e         dec_s;
  lamp_st_e         st_q;
  lamp_st_e         st_d;
  logic [CNT_W-1:0] ycnt_q;
  logic [CNT_W-1:0] ycnt_d;

  assign dec_s = decode_lamps(grn_i, ylw_i, red_i);
  assign dec_o = dec_s;
  assign st_o  = st_q;

  // Rule evaluation and next tracked state; a BAD sample freezes state and counter.
  always_comb begin
    st_d     = st_q;
    ycnt_d   = ycnt_q;
    lamp_o   = 1'b0;
    seq_o    = 1'b0;
    yshort_o = 1'b0;
    ylong_o  = 1'b0;
    if (dec_s == ST_BAD) begin
      lamp_o = 1'b1;
    end else begin
      st_d = dec_s;
      case (st_q)
        ST_RED:  seq_o = (dec_s == ST_YLW);
        ST_GRN:  seq_o = (dec_s == ST_RED);
        ST_YLW:  seq_o = (dec_s == ST_GRN);
        default: seq_o = 1'b0;
      endcase
      yshort_o = (st_q == ST_YLW) && (dec_s == ST_RED) && (ycnt_q < YMIN);
      if (dec_s == ST_YLW) begin
        // Saturation makes the YLONG edge fire only once per yellow interval.
        ylong_o = (ycnt_q == YMAX);
        if (ycnt_q != YSAT) begin
          ycnt_d = ycnt_q + CNT_W'(1);
        end else begin
          ycnt_d = ycnt_q;
        end
      end else begin
        ycnt_d = {CNT_W{1'b0}};
      end
    end
  end

  // Tracked state and yellow counter registers.
  always_ff @(posedge ck_i) begin
    if (!clr_i) begin
      st_q   <= ST_RED;
      ycnt_q <= {CNT_W{1'b0}};
    end else begin
      st_q   <= st_d;
      ycnt_q <= ycnt_d;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent checker on the two-direction lamp drives: samples the lamps, applies
// conflict and per-direction rules, latches the first fault and counts fault cycles.
module traffic_conflict_monitor
  import traffic_mon_pkg::*;
#(
  parameter int MIN_YLW = 2,
  parameter int MAX_YLW = 8,
  parameter int CNT_W   = 4,
  parameter int FCNT_W  = 8
) (
  input  logic              ck_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              ack_i,
  input  logic              grn1_i,
  input  logic              ylw1_i,
  input  logic              red1_i,
  input  logic              grn2_i,
  input  logic              ylw2_i,
  input  logic              red2_i,
  output logic              fault_o,
  output logic [2:0]        fault_code_o,
  output logic              fault_dir_o,
  output logic [FCNT_W-1:0] fault_cnt_o,
  output logic [1:0]        st1_o,
  output logic [1:0]        st2_o
);

  localparam logic [5:0]        SAMP_RST = 6'b001_001;
  localparam logic [FCNT_W-1:0] CNT_SAT  = {FCNT_W{1'b1}};

  logic [5:0]        samp_q;
  logic [1:0]        dec1_s;
  logic [1:0]        dec2_s;
  logic              lamp1_s, seq1_s, ysh1_s, ylong1_s;
  logic              lamp2_s, seq2_s, ysh2_s, ylong2_s;
  logic              conflict_s;
  logic              any_s;
  logic [2:0]        code_s;
  logic              dir_s;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d;
  logic              dir_q, dir_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;

  // Lamp sample register; the checks always look at last edge's lamps.
  always_ff @(posedge ck_i) begin
    if (!clr_i) begin
      samp_q <= SAMP_RST;
    end else begin
      samp_q <= {grn1_i, ylw1_i, red1_i, grn2_i, ylw2_i, red2_i};
    end
  end

  lamp_dir_checker #(.MIN_YLW(MIN_YLW), .MAX_YLW(MAX_YLW), .CNT_W(CNT_W)) u_dir1 (
    .ck_i     (ck_i),
    .clr_i    (clr_i),
    .grn_i    (samp_q[5]),
    .ylw_i    (samp_q[4]),
    .red_i    (samp_q[3]),
    .dec_o    (dec1_s),
    .st_o     (st1_o),
    .lamp_o   (lamp1_s),
    .seq_o    (seq1_s),
    .yshort_o (ysh1_s),
    .ylong_o  (ylong1_s)
  );

  lamp_dir_checker #(.MIN_YLW(MIN_YLW), .MAX_YLW(MAX_YLW), .CNT_W(CNT_W)) u_dir2 (
    .ck_i     (ck_i),
    .clr_i    (clr_i),
    .grn_i    (samp_q[2]),
    .ylw_i    (samp_q[1]),
    .red_i    (samp_q[0]),
    .dec_o    (dec2_s),
    .st_o     (st2_o),
    .lamp_o   (lamp2_s),
    .seq_o    (seq2_s),
    .yshort_o (ysh2_s),
    .ylong_o  (ylong2_s)
  );

  assign conflict_s = has_right_of_way(lamp_st_e'(dec1_s)) && has_right_of_way(lamp_st_e'(dec2_s));

  // Same-cycle priority encoder: rule order first, then dir1 before dir2.
  always_comb begin
    code_s = FC_NONE;
    dir_s  = 1'b0;
    any_s  = 1'b1;
    if (conflict_s) begin
      code_s = FC_CONFLICT;
    end else if (lamp1_s) begin
      code_s = FC_LAMP;
    end else if (lamp2_s) begin
      code_s = FC_LAMP;
      dir_s  = 1'b1;
    end else if (seq1_s) begin
      code_s = FC_SEQ;
    end else if (seq2_s) begin
      code_s = FC_SEQ;
      dir_s  = 1'b1;
    end else if (ysh1_s) begin
      code_s = FC_YSHORT;
    end else if (ysh2_s) begin
      code_s = FC_YSHORT;
      dir_s  = 1'b1;
    end else if (ylong1_s) begin
      code_s = FC_YLONG;
    end else if (ylong2_s) begin
      code_s = FC_YLONG;
      dir_s  = 1'b1;
    end else begin
      any_s  = 1'b0;
    end
  end

  // Fault latch and counter next state; a fault arriving with ACK is latched fresh.
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (en_i && any_s) begin
      if (!fault_q || ack_i) begin
        fault_d = 1'b1;
        code_d  = code_s;
        dir_d   = dir_s;
      end else begin
        fault_d = fault_q;
      end
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + FCNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (ack_i) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
      dir_d   = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault output registers.
  always_ff @(posedge ck_i) begin
    if (!clr_i) begin
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      dir_q   <= 1'b0;
      cnt_q   <= {FCNT_W{1'b0}};
    end else begin
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_code_o = code_q;
  assign fault_dir_o  = dir_q;
  assign fault_cnt_o  = cnt_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed self-checking bench for traffic_conflict_monitor with hand-computed expectations.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] L_R  = 3'b001;
  localparam logic [2:0] L_Y  = 3'b010;
  localparam logic [2:0] L_G  = 3'b100;
  localparam logic [2:0] L_GR = 3'b101;

  logic       ck_i = 1'b0;
  logic       clr_i, en_i, ack_i;
  logic       grn1_i, ylw1_i, red1_i, grn2_i, ylw2_i, red2_i;
  logic       fault_o;
  logic [2:0] fault_code_o;
  logic       fault_dir_o;
  logic [7:0] fault_cnt_o;
  logic [1:0] st1_o, st2_o;

  int n_checks = 0;
  int n_errs   = 0;

  traffic_conflict_monitor #(.MIN_YLW(2), .MAX_YLW(8), .CNT_W(4), .FCNT_W(8)) dut (
    .ck_i         (ck_i),
    .clr_i        (clr_i),
    .en_i         (en_i),
    .ack_i        (ack_i),
    .grn1_i       (grn1_i),
    .ylw1_i       (ylw1_i),
    .red1_i       (red1_i),
    .grn2_i       (grn2_i),
    .ylw2_i       (ylw2_i),
    .red2_i       (red2_i),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o),
    .fault_dir_o  (fault_dir_o),
    .fault_cnt_o  (fault_cnt_o),
    .st1_o        (st1_o),
    .st2_o        (st2_o)
  );

  always #5 ck_i = ~ck_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present lamps for n clock edges; returns 1 time unit after the last edge.
  task automatic drive(input logic [2:0] d1, input logic [2:0] d2, input int n);
    {grn1_i, ylw1_i, red1_i} = d1;
    {grn2_i, ylw2_i, red2_i} = d2;
    for (int i = 0; i < n; i++) begin
      @(posedge ck_i);
      #1;
    end
  endtask

  task automatic check_fault(input string tag, input logic f, input logic [2:0] c,
                             input logic d, input logic [7:0] n);
    check_eq({tag, "_fault"}, {31'd0, fault_o}, {31'd0, f});
    check_eq({tag, "_code"},  {29'd0, fault_code_o}, {29'd0, c});
    check_eq({tag, "_dir"},   {31'd0, fault_dir_o}, {31'd0, d});
    check_eq({tag, "_cnt"},   {24'd0, fault_cnt_o}, {24'd0, n});
  endtask

  initial begin
    clr_i = 1'b0;
    en_i  = 1'b1;
    ack_i = 1'b0;
    drive(L_R, L_R, 2);
    check_fault("reset", 1'b0, 3'd0, 1'b0, 8'd0);
    check_eq("reset_st1", {30'd0, st1_o}, 32'd0);
    check_eq("reset_st2", {30'd0, st2_o}, 32'd0);
    clr_i = 1'b1;

    // Legal cycle on dir1, then dir2.
    drive(L_G, L_R, 5);
    check_eq("legal_st1_grn", {30'd0, st1_o}, 32'd1);
    drive(L_Y, L_R, 3);
    check_eq("legal_st1_ylw", {30'd0, st1_o}, 32'd2);
    drive(L_R, L_R, 2);
    check_eq("legal_st1_red", {30'd0, st1_o}, 32'd0);
    drive(L_R, L_G, 5);
    check_eq("legal_st2_grn", {30'd0, st2_o}, 32'd1);
    drive(L_R, L_Y, 3);
    check_eq("legal_st2_ylw", {30'd0, st2_o}, 32'd2);
    drive(L_R, L_R, 2);
    check_eq("legal_st2_red", {30'd0, st2_o}, 32'd0);
    check_fault("legal", 1'b0, 3'd0, 1'b0, 8'd0);

    // Conflict: both green for one sample.
    drive(L_G, L_G, 1);
    check_eq("conf_lat1", {31'd0, fault_o}, 32'd0);
    drive(L_R, L_R, 1);
    check_fault("conf", 1'b1, 3'd1, 1'b0, 8'd1);
    en_i = 1'b0;
    drive(L_R, L_R, 2);
    check_fault("conf_en0", 1'b1, 3'd1, 1'b0, 8'd1);
    ack_i = 1'b1;
    drive(L_R, L_R, 1);
    ack_i = 1'b0;
    check_fault("conf_ack", 1'b0, 3'd0, 1'b0, 8'd1);
    en_i = 1'b1;

    // Short yellow on dir2, then a lamp fault that must not overwrite it.
    drive(L_R, L_G, 2);
    drive(L_R, L_Y, 1);
    drive(L_R, L_R, 2);
    check_fault("yshort", 1'b1, 3'd4, 1'b1, 8'd2);
    drive(L_GR, L_R, 1);
    drive(L_R, L_R, 1);
    check_fault("first_wins", 1'b1, 3'd4, 1'b1, 8'd3);
    check_eq("lamp_st1_hold", {30'd0, st1_o}, 32'd0);
    ack_i = 1'b1;
    drive(L_R, L_R, 1);
    ack_i = 1'b0;
    check_eq("yshort_ack", {31'd0, fault_o}, 32'd0);

    // Long yellow on dir1: 12 samples, YLONG on the 9th only.
    drive(L_G, L_R, 2);
    drive(L_Y, L_R, 8);
    check_eq("ylong_s7", {31'd0, fault_o}, 32'd0);
    drive(L_Y, L_R, 1);
    check_eq("ylong_s8", {31'd0, fault_o}, 32'd0);
    drive(L_Y, L_R, 1);
    check_fault("ylong_s9", 1'b1, 3'd5, 1'b0, 8'd4);
    drive(L_Y, L_R, 2);
    drive(L_R, L_R, 2);
    check_fault("ylong_end", 1'b1, 3'd5, 1'b0, 8'd4);
    check_eq("ylong_st1", {30'd0, st1_o}, 32'd0);

    // Yellow of exactly MIN_YLW samples is legal.
    drive(L_G, L_R, 2);
    drive(L_Y, L_R, 2);
    drive(L_R, L_R, 2);
    check_fault("ymin_ok", 1'b1, 3'd5, 1'b0, 8'd4);

    // GRN->RED with ACK on the latching edge: new fault latched fresh.
    drive(L_G, L_R, 2);
    drive(L_R, L_R, 1);
    ack_i = 1'b1;
    drive(L_R, L_R, 1);
    ack_i = 1'b0;
    check_fault("seq_ack", 1'b1, 3'd3, 1'b0, 8'd5);

    // Reset during dir1 yellow, then a yellow sample is a sequence fault.
    drive(L_G, L_R, 2);
    drive(L_Y, L_R, 2);
    check_eq("pre_rst_st1", {30'd0, st1_o}, 32'd2);
    clr_i = 1'b0;
    drive(L_Y, L_R, 1);
    check_fault("mid_rst", 1'b0, 3'd0, 1'b0, 8'd0);
    check_eq("mid_rst_st1", {30'd0, st1_o}, 32'd0);
    clr_i = 1'b1;
    drive(L_Y, L_R, 2);
    check_fault("rst_seq", 1'b1, 3'd3, 1'b0, 8'd1);

    // Same with logging disabled: state tracks, no fault.
    en_i  = 1'b0;
    clr_i = 1'b0;
    drive(L_Y, L_R, 1);
    clr_i = 1'b1;
    drive(L_Y, L_R, 2);
    check_fault("rst_en0", 1'b0, 3'd0, 1'b0, 8'd0);
    check_eq("rst_en0_st1", {30'd0, st1_o}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
